// File: rtl/led_blink_bank.sv
// Multi-channel LED pattern generator (OFF/ON/BLINK/BURST per channel) driven by one shared prescaler tick.
// LEDG registered, 1 cycle after a mode change; no backpressure, outputs free-run.
module led_blink_bank #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int N_CH     = 8,
  parameter int PER_W    = 16,
  parameter int BURST_W  = 4,
  parameter int PAUSE_HP = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic [2*N_CH-1:0]       mode,
  input  logic [PER_W*N_CH-1:0]   half_per,
  input  logic [BURST_W*N_CH-1:0] burst_cnt,
  output logic [N_CH-1:0]         LEDG,
  output logic                    tick
);
  localparam int P    = CLK_HZ / TICK_HZ;
  localparam int PS_W = (P > 1) ? $clog2(P) : 1;
  localparam int PZ_W = $clog2(PAUSE_HP + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(P - 1);
  localparam logic [PZ_W-1:0] PZ_LAST = PZ_W'(PAUSE_HP - 1);

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;
  localparam logic [1:0] M_BURST = 2'b11;

  typedef enum logic [1:0] {IDLE, ON_PH, OFF_PH, PAUSE} ch_state_t;

  logic [PS_W-1:0] ps_q;

  always_ff @(posedge CLOCK_50) begin
    if (RESET)                ps_q <= '0;
    else if (ps_q == PS_LAST) ps_q <= '0;
    else                      ps_q <= ps_q + PS_W'(1);
  end

  assign tick = (ps_q == PS_LAST);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [1:0]         md, mode_q, mode_d;
    logic [PER_W-1:0]   hp_in, hp_eff, hp_l, hp_d, cnt_q, cnt_d;
    logic [BURST_W-1:0] bc_in, bc_l, bc_d, pc_q, pc_d;
    logic [PZ_W-1:0]    pz_q, pz_d;
    logic               led_q, led_d, phase_end;
    ch_state_t          st_q, st_d;

    assign md        = mode[2*c +: 2];
    assign hp_in     = half_per[PER_W*c +: PER_W];
    assign bc_in     = burst_cnt[BURST_W*c +: BURST_W];
    assign hp_eff    = (hp_in == '0) ? PER_W'(1) : hp_in;
    assign phase_end = tick && (st_q != IDLE) && (cnt_q == hp_l - PER_W'(1));

    always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
        st_q   <= IDLE;
        mode_q <= M_OFF;
        cnt_q  <= '0;
        hp_l   <= '0;
        bc_l   <= '0;
        pc_q   <= '0;
        pz_q   <= '0;
        led_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        mode_q <= mode_d;
        cnt_q  <= cnt_d;
        hp_l   <= hp_d;
        bc_l   <= bc_d;
        pc_q   <= pc_d;
        pz_q   <= pz_d;
        led_q  <= led_d;
      end
    end

    // A mode change restarts the channel and swallows any tick on the same edge.
    always_comb begin
      st_d   = st_q;
      mode_d = mode_q;
      cnt_d  = cnt_q;
      hp_d   = hp_l;
      bc_d   = bc_l;
      pc_d   = pc_q;
      pz_d   = pz_q;
      if (md != mode_q) begin
        mode_d = md;
        cnt_d  = '0;
        hp_d   = hp_eff;
        bc_d   = bc_in;
        pc_d   = '0;
        pz_d   = '0;
        case (md)
          M_BLINK: st_d = ON_PH;
          M_BURST: st_d = (bc_in == '0) ? PAUSE : ON_PH;
          default: st_d = IDLE;
        endcase
      end else if (phase_end) begin
        cnt_d = '0;
        hp_d  = hp_eff;
        case (st_q)
          ON_PH: begin
            st_d = OFF_PH;
            if (mode_q == M_BURST) pc_d = pc_q + BURST_W'(1);
          end
          OFF_PH: begin
            if (mode_q == M_BURST && pc_q == bc_l) begin
              st_d = PAUSE;
              pc_d = '0;
            end else begin
              st_d = ON_PH;
            end
          end
          PAUSE: begin
            // A zero burst count keeps the channel parked here, re-checking each pause.
            if (pz_q == PZ_LAST) begin
              pz_d = '0;
              bc_d = bc_in;
              st_d = (bc_in == '0) ? PAUSE : ON_PH;
            end else begin
              pz_d = pz_q + PZ_W'(1);
            end
          end
          default: st_d = st_q;
        endcase
      end else if (tick && st_q != IDLE) begin
        cnt_d = cnt_q + PER_W'(1);
      end
      led_d = (st_d == ON_PH) || (st_d == IDLE && mode_d == M_ON);
    end

    assign LEDG[c] = led_q;
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// Randomized and directed bench for led_blink_bank against a countdown-style phase model.
// Small clock ratio (P=10) and four channels.
module tb_led_blink_bank;
  localparam int N   = 4;
  localparam int PW  = 16;
  localparam int BW  = 4;
  localparam int PHP = 4;
  localparam int P   = 10;
  localparam int K_IDLE = 0, K_ON = 1, K_OFF = 2, K_PAUSE = 3;

  logic          CLOCK_50 = 1'b0;
  logic          RESET = 1'b1;
  logic [2*N-1:0]  mode = '0;
  logic [PW*N-1:0] half_per = '0;
  logic [BW*N-1:0] burst_cnt = '0;
  logic [N-1:0]    LEDG;
  logic            tick;

  int n_cmp = 0;
  int n_bad = 0;

  int m_ps;
  int m_kind[N], m_left[N], m_pul[N], m_pz[N], m_bc[N], m_prev[N];

  led_blink_bank #(
    .CLK_HZ(1000), .TICK_HZ(100), .N_CH(N), .PER_W(PW), .BURST_W(BW), .PAUSE_HP(PHP)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .mode     (mode),
    .half_per (half_per),
    .burst_cnt(burst_cnt),
    .LEDG     (LEDG),
    .tick     (tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int hpe(input int c);
    int h;
    h = int'(half_per[PW*c +: PW]);
    return (h == 0) ? 1 : h;
  endfunction

  function automatic logic [N-1:0] exp_ledg();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++)
      v[c] = (m_kind[c] == K_ON) || (m_kind[c] == K_IDLE && m_prev[c] == 1);
    return v;
  endfunction

  // Each phase is a countdown of ticks; the next phase's length is read live at the boundary.
  task automatic model_edge();
    bit tk;
    int md;
    if (RESET) begin
      m_ps = 0;
      for (int c = 0; c < N; c++) begin
        m_kind[c] = K_IDLE; m_prev[c] = 0; m_left[c] = 0;
        m_pul[c] = 0; m_pz[c] = 0; m_bc[c] = 0;
      end
      return;
    end
    tk = (m_ps == P - 1);
    m_ps = tk ? 0 : m_ps + 1;
    for (int c = 0; c < N; c++) begin
      md = int'(mode[2*c +: 2]);
      if (md != m_prev[c]) begin
        m_prev[c] = md;
        m_left[c] = hpe(c);
        m_pul[c]  = 0;
        m_bc[c]   = int'(burst_cnt[BW*c +: BW]);
        if (md < 2) m_kind[c] = K_IDLE;
        else if (md == 2 || m_bc[c] != 0) m_kind[c] = K_ON;
        else begin m_kind[c] = K_PAUSE; m_pz[c] = PHP; end
      end else if (tk && m_kind[c] != K_IDLE) begin
        m_left[c]--;
        if (m_left[c] == 0) begin
          m_left[c] = hpe(c);
          case (m_kind[c])
            K_ON: begin m_kind[c] = K_OFF; m_pul[c]++; end
            K_OFF: begin
              if (md == 3 && m_pul[c] >= m_bc[c]) begin
                m_kind[c] = K_PAUSE; m_pz[c] = PHP; m_pul[c] = 0;
              end else m_kind[c] = K_ON;
            end
            default: begin
              m_pz[c]--;
              if (m_pz[c] == 0) begin
                m_bc[c] = int'(burst_cnt[BW*c +: BW]);
                if (m_bc[c] == 0) m_pz[c] = PHP;
                else m_kind[c] = K_ON;
              end
            end
          endcase
        end
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] el;
    logic et;
    @(posedge CLOCK_50);
    model_edge();
    el = exp_ledg();
    et = (m_ps == P - 1);
    #1;
    chk("ledg", 32'(LEDG), 32'(el));
    chk("tick", 32'(tick), 32'(et));
  endtask

  task automatic set_ch(input int c, input int m, input int hp, input int bc);
    mode[2*c +: 2]       = 2'(m);
    half_per[PW*c +: PW] = 16'(hp);
    burst_cnt[BW*c +: BW] = 4'(bc);
  endtask

  task automatic wait_led(input int c, input logic v);
    int n;
    n = 0;
    while (LEDG[c] !== v && n < 400) begin step(); n++; end
    if (LEDG[c] !== v) chk("wait_led_timeout", 32'(LEDG[c]), 32'(v));
  endtask

  // Length in cycles of the run the LED is currently in; optionally retunes half_per mid-run.
  task automatic measure(input int c, input int chg_at, input int chg_hp, output int n);
    logic v;
    v = LEDG[c];
    n = 0;
    while (LEDG[c] === v && n < 400) begin
      n++;
      if (n == chg_at) half_per[PW*c +: PW] = 16'(chg_hp);
      step();
    end
  endtask

  initial begin
    int n, ones;
    mode      = 8'($urandom);
    half_per  = {$urandom(), $urandom()};
    burst_cnt = 16'($urandom);
    RESET     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ledg", 32'(LEDG), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
    end
    RESET = 1'b0;
    mode  = '0;
    n = 1;
    while (tick !== 1'b1 && n < 30) begin step(); n++; end
    chk("first_tick_cycle", 32'(n), 32'd10);

    set_ch(0, 2, 3, 0); set_ch(1, 3, 1, 2); set_ch(2, 0, 1, 1); set_ch(3, 0, 1, 1);
    step();
    wait_led(0, 1'b0); wait_led(0, 1'b1);
    measure(0, -1, 0, n); chk("blink_hi", 32'(n), 32'd30);
    measure(0, -1, 0, n); chk("blink_lo", 32'(n), 32'd30);

    set_ch(1, 0, 1, 2); step(); set_ch(1, 3, 1, 2); step();
    measure(1, -1, 0, n);
    measure(1, -1, 0, n); chk("burst_gap", 32'(n), 32'd10);
    measure(1, -1, 0, n); chk("burst_p2", 32'(n), 32'd10);
    measure(1, -1, 0, n); chk("burst_pause", 32'(n), 32'd50);
    measure(1, -1, 0, n); chk("burst_p1", 32'(n), 32'd10);

    set_ch(2, 1, 1, 1); chk("on_pre", 32'(LEDG[2]), 32'd0);
    step();             chk("on_lat", 32'(LEDG[2]), 32'd1);
    set_ch(2, 0, 1, 1); chk("off_pre", 32'(LEDG[2]), 32'd1);
    step();             chk("off_lat", 32'(LEDG[2]), 32'd0);

    wait_led(0, 1'b0); wait_led(0, 1'b1);
    measure(0, 5, 5, n); chk("hp_chg_cur", 32'(n), 32'd30);
    measure(0, -1, 0, n); chk("hp_chg_next", 32'(n), 32'd50);

    n = 0;
    while (tick !== 1'b1 && n < 20) begin step(); n++; end
    chk("tick_seen", 32'(tick), 32'd1);
    set_ch(3, 2, 2, 1);
    step(); chk("coll_on", 32'(LEDG[3]), 32'd1);
    measure(3, -1, 0, n); chk("coll_len", 32'(n), 32'd20);

    set_ch(3, 2, 0, 1);
    wait_led(3, 1'b0); wait_led(3, 1'b1);
    measure(3, -1, 0, n); chk("hp0_hi", 32'(n), 32'd10);
    measure(3, -1, 0, n); chk("hp0_lo", 32'(n), 32'd10);

    set_ch(2, 3, 1, 0);
    ones = 0;
    for (int i = 0; i < 100; i++) begin step(); if (LEDG[2]) ones++; end
    chk("bc0_dark", 32'(ones), 32'd0);

    set_ch(1, 0, 1, 2); step(); set_ch(1, 3, 1, 2); step();
    wait_led(1, 1'b0); wait_led(1, 1'b1); step(); step();
    RESET = 1'b1;
    step(); chk("rst_mid_ledg", 32'(LEDG), 32'd0);
    RESET = 1'b0;
    step(); chk("rst_restart", 32'(LEDG[1]), 32'd1);
    measure(1, -1, 0, n);
    measure(1, -1, 0, n); chk("rst_gap", 32'(n), 32'd10);
    measure(1, -1, 0, n); chk("rst_p2", 32'(n), 32'd10);
    measure(1, -1, 0, n); chk("rst_pause", 32'(n), 32'd50);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0)
        set_ch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else if ($urandom_range(0, 39) == 0)
        half_per[PW*$urandom_range(0, 3) +: PW] = 16'($urandom_range(0, 4));
      RESET = ($urandom_range(0, 799) == 0);
      step();
    end
    RESET = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
